al4s3b_mult_regs_multich: RTL

Parametrised, multi-channel successor to the single-shot 32x32 multiplier register block. It is a Wishbone slave on the AHB-to-FPGA bridge and holds NUM_CH independent channels, each built around one `qlal4s3_mult_32x32_cell`. Each channel adds start/busy/done sequencing, a configurable result latency, a multiply-accumulate mode, sticky error and done status, and a maskable interrupt to the host.

---
 rtl/al4s3b_mult_regs_pkg.sv | 37 +++
 rtl/al4s3b_mult_channel.sv | 126 ++++++++++++
 rtl/qlal4s3_mult_32x32_cell.sv | 13 +
 rtl/al4s3b_mult_regs_multich.sv | 112 +++++++++++
 4 files changed

// File: rtl/al4s3b_mult_regs_pkg.sv
// Shared definitions for the multi-channel multiplier register block:
// register offsets, CTRL/STATUS bit positions, channel stride and channel FSM states.
// No ports; imported by the channel and top-level modules.
package al4s3b_mult_regs_pkg;

    // Global register block (channel slot 0)
    localparam logic [2:0] GADR_ID      = 3'd0;
    localparam logic [2:0] GADR_REV     = 3'd1;
    localparam logic [2:0] GADR_DONE    = 3'd2;
    localparam logic [2:0] GADR_IRQ_EN  = 3'd3;

    // Per-channel register offsets
    localparam logic [2:0] OFF_A        = 3'd0;
    localparam logic [2:0] OFF_B        = 3'd1;
    localparam logic [2:0] OFF_CTRL     = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_C_LO     = 3'd4;
    localparam logic [2:0] OFF_C_HI     = 3'd5;

    // Channel n occupies word addresses CH_STRIDE*(n+1) .. CH_STRIDE*(n+1)+7
    localparam int CH_STRIDE    = 8;

    localparam int CTRL_START   = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_CLR_ACC = 2;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_OVR       = 2;
    localparam int ST_MODE      = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ch_state_t;

endpackage

// File: rtl/al4s3b_mult_channel.sv
// One multiplier channel: A/B registers, operand snapshot, multiplier cell, latency FSM, accumulator, sticky status.
// Ports: clock/reset, decoded write strobes (wr_a/wr_b/wr_ctrl/wr_status) with byte enables and write data;
// outputs reg_a/reg_b/reg_c and status {mode, ovr, done, busy}.
module al4s3b_mult_channel
    import al4s3b_mult_regs_pkg::*;
#(
    parameter int MULT_LAT = 2
) (
    input  logic        WBs_CLK_i,
    input  logic        WBs_RST_i,
    input  logic        wr_a,
    input  logic        wr_b,
    input  logic        wr_ctrl,
    input  logic        wr_status,
    input  logic [3:0]  byte_stb,
    input  logic [31:0] wdat,
    output logic [31:0] reg_a,
    output logic [31:0] reg_b,
    output logic [63:0] reg_c,
    output logic [3:0]  status
);

    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_LAT - 1);

    ch_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   a_snap, b_snap;
    logic [63:0]   prod;
    logic          acc_snap;    // completion adds into C rather than overwriting it
    logic          busy, done, ovr, mode;
    logic          ctrl_wr, st_wr, accept, finish;

    assign ctrl_wr = wr_ctrl & byte_stb[0];
    assign st_wr   = wr_status & byte_stb[0];
    assign busy    = (state == BUSY);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_wr && wdat[CTRL_START]) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The cell sees the snapshot, so A/B writes during BUSY cannot disturb the operation in flight.
    qlal4s3_mult_32x32_cell u_mult (
        .Amult      (a_snap),
        .Bmult      (b_snap),
        .Valid_mult (busy),
        .Cmult      (prod)
    );

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state    <= IDLE;
            cnt      <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            reg_c    <= '0;
            a_snap   <= '0;
            b_snap   <= '0;
            acc_snap <= 1'b0;
            done     <= 1'b0;
            ovr      <= 1'b0;
            mode     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;

            for (int i = 0; i < 4; i++) begin
                if (wr_a && byte_stb[i]) reg_a[8*i +: 8] <= wdat[8*i +: 8];
                if (wr_b && byte_stb[i]) reg_b[8*i +: 8] <= wdat[8*i +: 8];
            end

            if (accept) begin
                a_snap   <= reg_a;
                b_snap   <= reg_b;
                mode     <= wdat[CTRL_MODE];
                acc_snap <= wdat[CTRL_MODE] & ~wdat[CTRL_CLR_ACC];
            end

            if (finish)
                reg_c <= acc_snap ? (reg_c + prod) : prod;
            else if (ctrl_wr && !busy && wdat[CTRL_CLR_ACC] && !wdat[CTRL_START])
                reg_c <= '0;

            // Completion beats a same-edge W1C so a finished result is never lost.
            if (finish)
                done <= 1'b1;
            else if (st_wr && wdat[ST_DONE])
                done <= 1'b0;

            if (ctrl_wr && busy && (wdat[CTRL_START] || wdat[CTRL_CLR_ACC]))
                ovr <= 1'b1;
            else if (st_wr && wdat[ST_OVR])
                ovr <= 1'b0;
        end
    end

    always_comb begin
        status           = '0;
        status[ST_BUSY]  = busy;
        status[ST_DONE]  = done;
        status[ST_OVR]   = ovr;
        status[ST_MODE]  = mode;
    end

endmodule

// File: rtl/qlal4s3_mult_32x32_cell.sv
// Behavioural stand-in for the hard 32x32 unsigned multiplier cell.
// Ports: Amult/Bmult operands, Valid_mult enables the product, Cmult 64-bit result.
// Output is zero while Valid_mult is low.
module qlal4s3_mult_32x32_cell (
    input  logic [31:0] Amult,
    input  logic [31:0] Bmult,
    input  logic        Valid_mult,
    output logic [63:0] Cmult
);

    assign Cmult = Valid_mult ? ({32'h0, Amult} * {32'h0, Bmult}) : 64'h0;

endmodule

// File: rtl/al4s3b_mult_regs_multich.sv
// Wishbone register block holding NUM_CH multiplier channels with done/overrun status and maskable interrupt.
// Ports: Wishbone slave (ADR/CYC/STB/WE/BYTE_STB/DAT in, DAT/ACK out), Device_ID_o constant,
// irq_o = registered OR of (done & irq_en), busy_o per-channel busy flags.
module al4s3b_mult_regs_multich
    import al4s3b_mult_regs_pkg::*;
#(
    parameter int          ADDRWIDTH     = 7,
    parameter int          DATAWIDTH     = 32,
    parameter int          NUM_CH        = 2,
    parameter int          MULT_LAT      = 2,
    parameter logic [31:0] DEVICE_ID     = 32'h12343232,
    parameter logic [15:0] REV_NO        = 16'h0200,
    parameter logic [31:0] DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
    input  logic                 WBs_CYC_i,
    input  logic                 WBs_STB_i,
    input  logic                 WBs_WE_i,
    input  logic [3:0]           WBs_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0] WBs_DAT_i,
    output logic [DATAWIDTH-1:0] WBs_DAT_o,
    output logic                 WBs_ACK_o,
    output logic [31:0]          Device_ID_o,
    output logic                 irq_o,
    output logic [NUM_CH-1:0]    busy_o
);

    localparam int OFW = $clog2(CH_STRIDE);
    localparam int CHW = ADDRWIDTH - OFW;

    logic [CHW-1:0]    adr_ch;
    logic [OFW-1:0]    adr_off;
    logic              wb_req, wb_wr;
    logic [NUM_CH-1:0] irq_en, done_vec;
    logic [31:0]       ch_a [NUM_CH];
    logic [31:0]       ch_b [NUM_CH];
    logic [63:0]       ch_c [NUM_CH];
    logic [3:0]        ch_st [NUM_CH];

    assign adr_ch      = WBs_ADR_i[ADDRWIDTH-1:OFW];
    assign adr_off     = WBs_ADR_i[OFW-1:0];
    // ~ACK makes every request a single-cycle ACK and a single register write.
    assign wb_req      = WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;
    assign wb_wr       = wb_req & WBs_WE_i;
    assign Device_ID_o = DEVICE_ID;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_hit;
        assign ch_hit = wb_wr && (adr_ch == CHW'(g + 1));

        al4s3b_mult_channel #(.MULT_LAT(MULT_LAT)) u_ch (
            .WBs_CLK_i (WBs_CLK_i),
            .WBs_RST_i (WBs_RST_i),
            .wr_a      (ch_hit && adr_off == OFF_A),
            .wr_b      (ch_hit && adr_off == OFF_B),
            .wr_ctrl   (ch_hit && adr_off == OFF_CTRL),
            .wr_status (ch_hit && adr_off == OFF_STATUS),
            .byte_stb  (WBs_BYTE_STB_i),
            .wdat      (WBs_DAT_i),
            .reg_a     (ch_a[g]),
            .reg_b     (ch_b[g]),
            .reg_c     (ch_c[g]),
            .status    (ch_st[g])
        );

        assign done_vec[g] = ch_st[g][ST_DONE];
        assign busy_o[g]   = ch_st[g][ST_BUSY];
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            WBs_ACK_o <= 1'b0;
            irq_en    <= '0;
            irq_o     <= 1'b0;
        end else begin
            WBs_ACK_o <= wb_req;
            if (wb_wr && adr_ch == '0 && adr_off == GADR_IRQ_EN && WBs_BYTE_STB_i[0])
                irq_en <= WBs_DAT_i[NUM_CH-1:0];
            irq_o <= |(done_vec & irq_en);
        end
    end

    always_comb begin
        WBs_DAT_o = DEF_REG_VALUE;
        if (adr_ch == '0) begin
            case (adr_off)
                GADR_ID:     WBs_DAT_o = DEVICE_ID;
                GADR_REV:    WBs_DAT_o = {16'h0, REV_NO};
                GADR_DONE:   WBs_DAT_o = 32'(done_vec);
                GADR_IRQ_EN: WBs_DAT_o = 32'(irq_en);
                default:     WBs_DAT_o = DEF_REG_VALUE;
            endcase
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (adr_ch == CHW'(n + 1)) begin
                    case (adr_off)
                        OFF_A:      WBs_DAT_o = ch_a[n];
                        OFF_B:      WBs_DAT_o = ch_b[n];
                        OFF_CTRL:   WBs_DAT_o = 32'h0;
                        OFF_STATUS: WBs_DAT_o = 32'(ch_st[n]);
                        OFF_C_LO:   WBs_DAT_o = ch_c[n][31:0];
                        OFF_C_HI:   WBs_DAT_o = ch_c[n][63:32];
                        default:    WBs_DAT_o = DEF_REG_VALUE;
                    endcase
                end
            end
        end
    end

endmodule
